// File: rtl/dff_pipeline.sv
// Parametrised register delay line: DEPTH WIDTH-bit stages, each with its own
// valid bit, joined by a combinational ready chain with bubble collapse and flush.
module dff_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OCC_W-1:0] occ;

  // A stage is ready when it or any stage downstream of it is empty, or the
  // consumer is taking the output; accumulating from the output end keeps this
  // a plain function of vld_q rather than a bit-to-bit loop inside rdy.
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      acc = acc | ~vld_q[DEPTH-1-k];
      rdy[DEPTH-1-k] = acc;
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (flush) begin
      vld_d = '0;
    end else begin
      if (rdy[0]) begin
        vld_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = in_data;
        end
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld_d[i] = vld_q[i-1];
          if (vld_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(vld_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ;

endmodule

// File: tb/tb_dff_pipeline.sv
// Bench for dff_pipeline: a default (8x3) and a minimal (1x1) instance share one
// stimulus stream and are checked against a word-position reference model.
module tb_dff_pipeline;

  localparam int DA = 3;
  localparam int DB = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, in_valid, out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_occ;
  logic       b_in_ready, b_out_valid;
  logic [0:0] b_out_data;
  logic [0:0] b_occ;
  logic [0:0] b_in_data;

  assign b_in_data = in_data[0];

  always #5 clk = ~clk;

  dff_pipeline #(.WIDTH(8), .DEPTH(DA)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  dff_pipeline #(.WIDTH(1), .DEPTH(DB)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  // Model: per instance, the words inside in arrival order (index 0 = oldest)
  // together with the stage position each one currently occupies.
  int         mpos [2][4];
  logic [7:0] mdat [2][4];
  int         mcnt [2];
  int         n_chk = 0;
  int         n_pass = 0;

  function automatic int depth_of(input int s);
    return (s == 0) ? DA : DB;
  endfunction

  function automatic logic exp_in_ready(input int s);
    return !flush && ((mcnt[s] < depth_of(s)) || out_ready);
  endfunction

  function automatic logic exp_out_valid(input int s);
    return (mcnt[s] > 0) && (mpos[s][0] == depth_of(s) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mcnt[0] = 0;
    mcnt[1] = 0;
  endtask

  task automatic model_edge(input int s, input logic fl, input logic iv,
                            input logic [7:0] id, input logic ordy);
    int   d, c, limit, np;
    logic acc;
    d   = depth_of(s);
    c   = mcnt[s];
    acc = !fl && ((c < d) || ordy);
    if (fl) begin
      mcnt[s] = 0;
    end else begin
      if (ordy && c > 0 && mpos[s][0] == d - 1) begin
        for (int k = 1; k < c; k++) begin
          mpos[s][k-1] = mpos[s][k];
          mdat[s][k-1] = mdat[s][k];
        end
        c--;
      end
      // each word steps forward one stage unless the word ahead still sits there
      limit = d;
      for (int k = 0; k < c; k++) begin
        np = (mpos[s][k] + 1 < limit) ? mpos[s][k] + 1 : mpos[s][k];
        mpos[s][k] = np;
        limit = np;
      end
      if (iv && acc) begin
        mpos[s][c] = 0;
        mdat[s][c] = (s == 0) ? id : {7'd0, id[0]};
        c++;
      end
      mcnt[s] = c;
    end
  endtask

  task automatic check_outputs();
    chk("a_in_ready",  {31'd0, a_in_ready},  {31'd0, exp_in_ready(0)});
    chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, exp_out_valid(0)});
    chk("a_occupancy", {30'd0, a_occ},       mcnt[0]);
    if (exp_out_valid(0)) chk("a_out_data", {24'd0, a_out_data}, {24'd0, mdat[0][0]});
    chk("b_in_ready",  {31'd0, b_in_ready},  {31'd0, exp_in_ready(1)});
    chk("b_out_valid", {31'd0, b_out_valid}, {31'd0, exp_out_valid(1)});
    chk("b_occupancy", {31'd0, b_occ},       mcnt[1]);
    if (exp_out_valid(1)) chk("b_out_data", {31'd0, b_out_data}, {24'd0, mdat[1][0]});
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic step();
    logic       fl, iv, ordy;
    logic [7:0] id;
    #1;
    check_outputs();
    fl = flush; iv = in_valid; id = in_data; ordy = out_ready;
    @(posedge clk);
    model_edge(0, fl, iv, id, ordy);
    model_edge(1, fl, iv, id, ordy);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int idx;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_out_data", {24'd0, a_out_data}, 32'd0);
    chk("rst_a_occ", {30'd0, a_occ}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // stream 1..10 with the consumer always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    idle(5);

    // backpressure: A1..A5 against a stalled consumer
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'hA1 + 8'(idx);
      if (exp_in_ready(0)) idx++;
      step();
    end
    #1;
    chk("bp_occ", {30'd0, a_occ}, 32'd3);
    chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("bp_out_data", {24'd0, a_out_data}, 32'hA1);
    out_ready = 1'b1;
    while (idx < 5) begin
      in_valid = 1'b1; in_data = 8'hA1 + 8'(idx);
      if (exp_in_ready(0)) idx++;
      step();
    end
    idle(5);

    // bubble collapse: 0x11, two idle cycles, 0x22, consumer stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step();
    idle(2);
    in_valid = 1'b1; in_data = 8'h22; step();
    idle(1);
    #1;
    chk("bubble_occ", {30'd0, a_occ}, 32'd2);
    out_ready = 1'b1;
    idle(4);

    // flush with a word offered in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i); step();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55; step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_occ", {30'd0, a_occ}, 32'd0);
    chk("flush_out_valid", {31'd0, a_out_valid}, 32'd0);
    out_ready = 1'b1;
    idle(4);

    // full pipeline with simultaneous input and output
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h60 + 8'(i); step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'h70 + 8'(i);
      #1;
      chk("full_in_ready", {31'd0, a_in_ready}, 32'd1);
      chk("full_occ", {30'd0, a_occ}, 32'd3);
      step();
    end
    idle(4);

    // asynchronous reset with three words inside
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h80 + 8'(i); step();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("amid_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("amid_out_data", {24'd0, a_out_data}, 32'd0);
    chk("amid_occ", {30'd0, a_occ}, 32'd0);
    chk("bmid_occ", {31'd0, b_occ}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 19) == 0);
      in_data   = 8'($urandom);
      step();
    end
    flush = 1'b0; out_ready = 1'b1;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
